debug_scan_ctrl: RTL and testbench

- Parametrised system-clock debug scan controller: the next generation of the CPU debug-slave tck/sysclk pair, merged into one clock domain.
- Receives virtual-JTAG state strobes that are already synchronised into clk. Captures one of NCH status words, shifts it out while shifting host data in, and on update presents the data word with per-channel action/no-action requests.
- Adds a bit-count length check, a ready/valid hold of pending requests, and sticky error flags.
- Sits between the virtual-JTAG bridge and the debug register/OCI-memory logic.

---
 rtl/debug_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_debug_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/debug_scan_ctrl.sv
// System-clock debug scan controller: captures a channel status word, shifts it out
// against host data, and presents the update word as a held action/no-action request.
module debug_scan_ctrl #(
    parameter int IR_W = 2,
    parameter int DR_W = 38,
    parameter int NCH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vs_uir,
    input  logic                vs_cdr,
    input  logic                vs_sdr,
    input  logic                vs_udr,
    input  logic                shift_en,
    input  logic                tdi,
    input  logic [IR_W-1:0]     ir_in,
    input  logic [NCH*DR_W-1:0] cap_data,
    input  logic                act_ready,
    output logic                tdo,
    output logic [1:0]          ir_out,
    output logic [DR_W-1:0]     jdo,
    output logic [NCH-1:0]      take_action,
    output logic [NCH-1:0]      take_no_action,
    output logic                busy
);

    localparam int CNT_W = $clog2(DR_W + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE
    } state_t;

    state_t           r_state;
    logic [DR_W-1:0]  r_sr;
    logic [DR_W-1:0]  r_jdo;
    logic [IR_W-1:0]  r_ir;
    logic [IR_W-1:0]  r_scan_ir;
    logic [CNT_W-1:0] r_bitcnt;
    logic             r_err;
    logic [NCH-1:0]   r_ta;
    logic [NCH-1:0]   r_tna;

    logic [DR_W-1:0]  w_cap;
    logic [NCH-1:0]   w_cap_sel;
    logic [NCH-1:0]   w_scan_sel;
    logic             w_pend;
    logic             w_scan_ok;
    logic             w_err_clr;

    // Channel decode by loop so an ir beyond NCH simply selects nothing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_cap      = '0;
        w_cap_sel  = '0;
        w_scan_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            w_cap_sel[k]  = (r_ir == IR_W'(k));
            w_scan_sel[k] = (r_scan_ir == IR_W'(k));
            if (w_cap_sel[k]) w_cap = cap_data[k*DR_W +: DR_W];
        end
    end

    assign w_pend    = |(r_ta | r_tna);
    assign w_scan_ok = (r_bitcnt == CNT_W'(DR_W)) && (|w_scan_sel);
    assign w_err_clr = vs_uir && (&ir_in);

    // NOTE: sequential state uses non-blocking assignments only, so later reads see old values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_jdo     <= '0;
            r_ir      <= '0;
            r_scan_ir <= '0;
            r_bitcnt  <= '0;
            r_err     <= 1'b0;
            r_ta      <= '0;
            r_tna     <= '0;
        end else begin
            if (vs_uir) r_ir <= ir_in;

            if (act_ready && w_pend) begin
                r_ta  <= '0;
                r_tna <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (vs_cdr) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // The scan is bound to the channel latched here, not to later ir writes.
                    r_sr      <= w_cap;
                    r_scan_ir <= r_ir;
                    r_bitcnt  <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (shift_en && vs_sdr) begin
                        r_sr <= {tdi, r_sr[DR_W-1:1]};
                        if (r_bitcnt != CNT_W'(DR_W + 1)) r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    if (vs_cdr)      r_state <= S_CAPTURE;
                    else if (vs_udr) r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (!w_scan_ok || w_pend) begin
                        r_err <= 1'b1;
                    end else begin
                        r_jdo <= r_sr;
                        r_ta  <= r_sr[DR_W-1] ? w_scan_sel : '0;
                        r_tna <= r_sr[DR_W-1] ? '0 : w_scan_sel;
                    end
                    r_state <= vs_cdr ? S_CAPTURE : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Clearing via an all-ones ir write wins over any error raised this cycle.
            if (w_err_clr) r_err <= 1'b0;
        end
    end

    assign tdo            = r_sr[0];
    assign ir_out         = {r_err, w_pend};
    assign jdo            = r_jdo;
    assign take_action    = r_ta;
    assign take_no_action = r_tna;
    assign busy           = (r_state != S_IDLE) || w_pend;

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Directed bench for debug_scan_ctrl: table of full scans plus hand-built corner sequences,
// with a second NCH=3 instance for the out-of-range channel case.
module tb_debug_scan_ctrl;

    localparam logic [37:0] CH0 = 38'h3F_FFFF_FFFF;
    localparam logic [37:0] CH1 = 38'h02_1234_5678;
    localparam logic [37:0] CH2 = 38'h01_0000_0001;
    localparam logic [37:0] CH3 = 38'h0A_5A5A_C3C3;

    logic         clk = 1'b0;
    logic         reset, vs_uir, vs_cdr, vs_sdr, vs_udr, shift_en, tdi, act_ready;
    logic [1:0]   ir_in;
    logic [151:0] cap4;
    logic [113:0] cap3;

    logic         tdo4, busy4, tdo3, busy3;
    logic [1:0]   ir_out4, ir_out3;
    logic [37:0]  jdo4, jdo3;
    logic [3:0]   ta4, tna4;
    logic [2:0]   ta3, tna3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] tdi_w;
        logic [37:0] exp_tdo_w;
        logic [37:0] exp_jdo;
        logic [3:0]  exp_ta;
        logic [3:0]  exp_tna;
    } vec_t;

    vec_t vecs[4];

    debug_scan_ctrl #(.IR_W(2), .DR_W(38), .NCH(4)) u4 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .shift_en(shift_en), .tdi(tdi), .ir_in(ir_in), .cap_data(cap4),
        .act_ready(act_ready), .tdo(tdo4), .ir_out(ir_out4), .jdo(jdo4),
        .take_action(ta4), .take_no_action(tna4), .busy(busy4)
    );

    debug_scan_ctrl #(.IR_W(2), .DR_W(38), .NCH(3)) u3 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .shift_en(shift_en), .tdi(tdi), .ir_in(ir_in), .cap_data(cap3),
        .act_ready(act_ready), .tdo(tdo3), .ir_out(ir_out3), .jdo(jdo3),
        .take_action(ta3), .take_no_action(tna3), .busy(busy3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    // Full scan: ir write, capture, nbits shifts, update; returns the bits seen on tdo.
    task automatic do_scan(input logic [1:0] ir, input int nbits, input logic [37:0] word,
                           input logic act, input bit use3, output logic [37:0] got);
        got = '0;
        ir_in = ir; vs_uir = 1'b1; tick(); vs_uir = 1'b0;
        vs_cdr = 1'b1; tick(); vs_cdr = 1'b0; tick();
        vs_sdr = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            got[i]   = use3 ? tdo3 : tdo4;
            tdi      = word[i];
            shift_en = 1'b1;
            tick();
        end
        shift_en = 1'b0; vs_sdr = 1'b0; tdi = 1'b0;
        act_ready = act; vs_udr = 1'b1; tick(); vs_udr = 1'b0; tick();
    endtask

    initial begin
        logic [37:0] got;

        vecs[0] = '{ir: 2'd1, tdi_w: 38'h20_0000_00AB, exp_tdo_w: CH1,
                    exp_jdo: 38'h20_0000_00AB, exp_ta: 4'b0010, exp_tna: 4'b0000};
        vecs[1] = '{ir: 2'd0, tdi_w: 38'h15_5555_5555, exp_tdo_w: CH0,
                    exp_jdo: 38'h15_5555_5555, exp_ta: 4'b0000, exp_tna: 4'b0001};
        vecs[2] = '{ir: 2'd3, tdi_w: 38'h3A_DEAD_BEEF, exp_tdo_w: CH3,
                    exp_jdo: 38'h3A_DEAD_BEEF, exp_ta: 4'b1000, exp_tna: 4'b0000};
        vecs[3] = '{ir: 2'd2, tdi_w: 38'h00_0000_0001, exp_tdo_w: CH2,
                    exp_jdo: 38'h00_0000_0001, exp_ta: 4'b0000, exp_tna: 4'b0100};

        cap4 = {CH3, CH2, CH1, CH0};
        cap3 = {CH2, CH1, CH0};
        vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0; shift_en = 0; tdi = 0;
        act_ready = 0; ir_in = 0;

        do_reset(3);
        check("rst_tdo", tdo4, 0);
        check("rst_ir_out", ir_out4, 2'b00);
        check("rst_jdo", jdo4, 0);
        check("rst_ta", ta4, 0);
        check("rst_tna", tna4, 0);
        check("rst_busy", busy4, 0);

        for (int r = 0; r < 4; r++) begin
            do_scan(vecs[r].ir, 38, vecs[r].tdi_w, 1'b1, 1'b0, got);
            check($sformatf("v%0d_tdo_word", r), got, vecs[r].exp_tdo_w);
            check($sformatf("v%0d_jdo", r), jdo4, vecs[r].exp_jdo);
            check($sformatf("v%0d_ta", r), ta4, vecs[r].exp_ta);
            check($sformatf("v%0d_tna", r), tna4, vecs[r].exp_tna);
            check($sformatf("v%0d_ir_out", r), ir_out4, 2'b01);
            tick();
            check($sformatf("v%0d_req_clr", r), {ta4, tna4}, 8'h00);
            check($sformatf("v%0d_ir_out_clr", r), ir_out4, 2'b00);
            check($sformatf("v%0d_busy_clr", r), busy4, 0);
            act_ready = 1'b0;
        end

        // Reset mid-shift with a request pending aborts everything.
        do_scan(2'd3, 38, 38'h3A_DEAD_BEEF, 1'b0, 1'b0, got);
        check("pre_rst_ta", ta4, 4'b1000);
        vs_cdr = 1'b1; tick(); vs_cdr = 1'b0; tick();
        vs_sdr = 1'b1; shift_en = 1'b1; tdi = 1'b1;
        repeat (5) tick();
        check("mid_shift_busy", busy4, 1);
        vs_cdr = 1'b1; vs_udr = 1'b1;
        do_reset(3);
        vs_cdr = 0; vs_udr = 0; vs_sdr = 0; shift_en = 0; tdi = 0;
        check("mrst_tdo", tdo4, 0);
        check("mrst_ir_out", ir_out4, 2'b00);
        check("mrst_jdo", jdo4, 0);
        check("mrst_req", {ta4, tna4}, 8'h00);
        check("mrst_busy", busy4, 0);

        // No-action request held while the consumer is not ready.
        do_scan(2'd2, 38, 38'h00_0000_0001, 1'b0, 1'b0, got);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d_tna", c), tna4, 4'b0100);
            check($sformatf("hold%0d_pend", c), ir_out4[0], 1'b1);
            tick();
        end
        check("hold_before_ack", tna4, 4'b0100);
        act_ready = 1'b1; tick(); act_ready = 1'b0;
        check("hold_after_ack", tna4, 4'b0000);
        check("hold_ir_out", ir_out4, 2'b00);

        // Short scan: length error, no request, jdo untouched, error cleared by ir=all-ones.
        do_scan(2'd1, 37, 38'h20_0000_00AB, 1'b1, 1'b0, got);
        act_ready = 1'b0;
        check("short_req", {ta4, tna4}, 8'h00);
        check("short_jdo", jdo4, 38'h00_0000_0001);
        check("short_ir_out", ir_out4, 2'b10);
        ir_in = 2'b11; vs_uir = 1'b1; tick(); vs_uir = 1'b0;
        check("err_clear", ir_out4, 2'b00);

        // Overrun: second update while the first request is still held.
        do_scan(2'd0, 38, 38'h00_1111_2222, 1'b0, 1'b0, got);
        check("ovr_first_tna", tna4, 4'b0001);
        check("ovr_first_jdo", jdo4, 38'h00_1111_2222);
        do_scan(2'd0, 38, 38'h3F_0000_FFFF, 1'b0, 1'b0, got);
        check("ovr_ir_out", ir_out4, 2'b11);
        check("ovr_jdo_kept", jdo4, 38'h00_1111_2222);
        check("ovr_req_held", {ta4, tna4}, 8'h01);
        act_ready = 1'b1; tick(); act_ready = 1'b0;
        check("ovr_ack", ir_out4, 2'b10);

        // Out-of-range channel on the NCH=3 instance.
        do_reset(1);
        do_scan(2'd3, 38, 38'h20_0000_0001, 1'b1, 1'b1, got);
        act_ready = 1'b0;
        check("oor_tdo_word", got, 38'h0);
        check("oor_ir_out", ir_out3, 2'b10);
        check("oor_req", {ta3, tna3}, 6'h00);
        check("oor_jdo", jdo3, 38'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
